// File: rtl/fwd_hazard_scoreboard_pkg.sv
// Shared definitions for the forward/hazard scoreboard.
// Holds default parameter values, the register-file select encoding and
// the helper that sizes the per-port forward select field.
package fwd_hazard_scoreboard_pkg;

  localparam int AW_DEF      = 5;
  localparam int NUM_SRC_DEF = 3;
  localparam int NUM_STG_DEF = 3;
  localparam int LW_DEF      = 3;
  localparam int SW_DEF      = 16;

  // Select value meaning "take the operand from the register file".
  localparam int FWD_RF = 0;

  // Width of one port's select: encodes 0 (RF) plus one code per stage.
  function automatic int sel_width(input int num_stg);
    return (num_stg < 1) ? 1 : $clog2(num_stg + 1);
  endfunction

endpackage

// File: rtl/fwd_hazard_scoreboard_if.sv
// Bundle of the issue, consumer and producer-stage signals of the
// forward/hazard scoreboard.
//   master : the pipeline control side driving issue/source/stage info
//   slave  : the scoreboard, returning fwd_sel, stall and stall_cnt
interface fwd_hazard_scoreboard_if
  import fwd_hazard_scoreboard_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int NUM_STG = NUM_STG_DEF,
  parameter int LW      = LW_DEF,
  parameter int SW      = SW_DEF
) ();

  localparam int SELW = sel_width(NUM_STG);

  logic                      flush;
  logic                      iss_valid;
  logic                      iss_we;
  logic [AW-1:0]             iss_rd;
  logic [LW-1:0]             iss_lat;
  logic [NUM_SRC*AW-1:0]     src_addr;
  logic [NUM_SRC-1:0]        src_used;
  logic [NUM_STG-1:0]        stg_we;
  logic [NUM_STG*AW-1:0]     stg_rd;
  logic [NUM_STG-1:0]        stg_rdy;
  logic [NUM_SRC*SELW-1:0]   fwd_sel;
  logic                      stall;
  logic [SW-1:0]             stall_cnt;

  modport master (
    output flush, iss_valid, iss_we, iss_rd, iss_lat,
    output src_addr, src_used, stg_we, stg_rd, stg_rdy,
    input  fwd_sel, stall, stall_cnt
  );

  modport slave (
    input  flush, iss_valid, iss_we, iss_rd, iss_lat,
    input  src_addr, src_used, stg_we, stg_rd, stg_rdy,
    output fwd_sel, stall, stall_cnt
  );

endinterface

// File: rtl/fwd_hazard_scoreboard_port_sel.sv
// Forward select for one consumer port.
// Priority encoder across producer stages: the youngest matching stage
// (lowest index) wins. If that stage's value is not ready yet the port is
// flagged not-ready; older matches are never used because they are stale.
//   src_addr_i/src_used_i : consumer register and whether it is read
//   stg_we_i/stg_rd_i/stg_rdy_i : producer stage write enable, dest, ready
//   sel_o     : 0 = register file, s+1 = stage s
//   not_rdy_o : youngest match exists but its value is not valid yet
module fwd_hazard_scoreboard_port_sel
  import fwd_hazard_scoreboard_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int NUM_STG = NUM_STG_DEF,
  parameter int SELW    = sel_width(NUM_STG_DEF)
) (
  input  logic [AW-1:0]         src_addr_i,
  input  logic                  src_used_i,
  input  logic [NUM_STG-1:0]    stg_we_i,
  input  logic [NUM_STG*AW-1:0] stg_rd_i,
  input  logic [NUM_STG-1:0]    stg_rdy_i,
  output logic [SELW-1:0]       sel_o,
  output logic                  not_rdy_o
);

  logic [NUM_STG-1:0] match_s;

  // Per-stage address match; register 0 never forwards.
  always_comb begin
    match_s = {NUM_STG{1'b0}};
    for (int s = 0; s < NUM_STG; s++) begin
      match_s[s] = src_used_i & stg_we_i[s]
                 & (stg_rd_i[s*AW +: AW] == src_addr_i)
                 & (src_addr_i != {AW{1'b0}});
    end
  end

  // Walk oldest to youngest so the youngest match overwrites the rest.
  always_comb begin
    sel_o     = SELW'(FWD_RF);
    not_rdy_o = 1'b0;
    for (int s = NUM_STG - 1; s >= 0; s--) begin
      sel_o     = match_s[s] ? SELW'(s + 1) : sel_o;
      not_rdy_o = match_s[s] ? ~stg_rdy_i[s] : not_rdy_o;
    end
  end

endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// Forward select and latency scoreboard between ID and the pipeline regs.
// Per consumer port it picks the youngest forwarding stage, and a per-
// register countdown tracks multi-cycle producers so decode can stall
// until their results become forwardable.
//   clk   : clock, all state on rising edge
//   reset : asynchronous, active-low, clears scoreboard and stall_cnt
//   bus   : slave side of fwd_hazard_scoreboard_if (issue, sources,
//           stages in; fwd_sel/stall combinational out, stall_cnt registered)
module fwd_hazard_scoreboard
  import fwd_hazard_scoreboard_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int NUM_STG = NUM_STG_DEF,
  parameter int LW      = LW_DEF,
  parameter int SW      = SW_DEF
) (
  input logic                  clk,
  input logic                  reset,
  fwd_hazard_scoreboard_if.slave bus
);

  localparam int SELW = sel_width(NUM_STG);
  localparam int NREG = 2 ** AW;

  logic [AW-1:0]           addr_s [NUM_SRC];
  logic [NUM_SRC*SELW-1:0] fwd_sel_s;
  logic [NUM_SRC-1:0]      not_rdy_s;
  logic                    stall_s;
  logic                    iss_acc_s;

  logic [LW-1:0] cnt_q [NREG];
  logic [LW-1:0] cnt_d [NREG];
  logic [SW-1:0] stall_cnt_q;
  logic [SW-1:0] stall_cnt_d;

  // Unpack per-port source addresses.
  always_comb begin
    for (int p = 0; p < NUM_SRC; p++) begin
      addr_s[p] = bus.src_addr[p*AW +: AW];
    end
  end

  for (genvar p = 0; p < NUM_SRC; p++) begin : g_port
    fwd_hazard_scoreboard_port_sel #(
      .AW      (AW),
      .NUM_STG (NUM_STG),
      .SELW    (SELW)
    ) u_sel (
      .src_addr_i (addr_s[p]),
      .src_used_i (bus.src_used[p]),
      .stg_we_i   (bus.stg_we),
      .stg_rd_i   (bus.stg_rd),
      .stg_rdy_i  (bus.stg_rdy),
      .sel_o      (fwd_sel_s[p*SELW +: SELW]),
      .not_rdy_o  (not_rdy_s[p])
    );
  end

  // A port stalls decode if its register is still counting down or its
  // youngest forwarding source is not ready.
  always_comb begin
    stall_s = 1'b0;
    for (int p = 0; p < NUM_SRC; p++) begin
      stall_s = stall_s
              | (bus.src_used[p] & (addr_s[p] != {AW{1'b0}})
                 & ((cnt_q[addr_s[p]] != {LW{1'b0}}) | not_rdy_s[p]));
    end
  end

  assign iss_acc_s = bus.iss_valid & ~stall_s & bus.iss_we
                   & (bus.iss_rd != {AW{1'b0}});

  // Scoreboard next state: flush beats issue, issue beats decrement.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      if (r == 0) begin
        cnt_d[r] = {LW{1'b0}};
      end else if (bus.flush) begin
        cnt_d[r] = {LW{1'b0}};
      end else if (iss_acc_s && (bus.iss_rd == AW'(r))) begin
        cnt_d[r] = bus.iss_lat;
      end else if (cnt_q[r] != {LW{1'b0}}) begin
        cnt_d[r] = cnt_q[r] - {{(LW-1){1'b0}}, 1'b1};
      end else begin
        cnt_d[r] = cnt_q[r];
      end
    end
  end

  // Saturating stall-cycle counter next state.
  always_comb begin
    if (stall_s && (stall_cnt_q != {SW{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(SW-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= {LW{1'b0}};
      end
      stall_cnt_q <= {SW{1'b0}};
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.fwd_sel   = fwd_sel_s;
  assign bus.stall     = stall_s;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
module tb_fwd_hazard_scoreboard;

  localparam int AW = 5, NSRC = 3, NSTG = 3, LW = 3, SW = 16, SELW = 2;
  localparam int SAT = (2 ** SW) - 1;

  logic clk;
  logic reset;

  fwd_hazard_scoreboard_if #(.AW(AW), .NUM_SRC(NSRC), .NUM_STG(NSTG), .LW(LW), .SW(SW)) bus ();

  fwd_hazard_scoreboard #(.AW(AW), .NUM_SRC(NSRC), .NUM_STG(NSTG), .LW(LW), .SW(SW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // stimulus in plain form
  int t_src [NSRC];
  bit t_used [NSRC];
  bit t_we [NSTG];
  int t_rd [NSTG];
  bit t_rdy [NSTG];
  bit t_iv, t_iwe, t_flush;
  int t_ird, t_ilat;

  // reference model state
  int mcnt [32];
  int msc;
  int exp_sel [NSRC];
  bit exp_stall;

  typedef struct packed {
    logic [2:0][4:0] src;
    logic [2:0]      used;
    logic [2:0]      we;
    logic [2:0][4:0] rd;
    logic [2:0]      rdy;
    logic [2:0][1:0] esel;
    logic            estall;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int get_sel(input int p);
    return int'(bus.fwd_sel[p*SELW +: SELW]);
  endfunction

  task automatic idle();
    for (int p = 0; p < NSRC; p++) begin t_src[p] = 0; t_used[p] = 0; end
    for (int s = 0; s < NSTG; s++) begin t_we[s] = 0; t_rd[s] = 0; t_rdy[s] = 1; end
    t_iv = 0; t_iwe = 0; t_flush = 0; t_ird = 0; t_ilat = 0;
  endtask

  task automatic push();
    for (int p = 0; p < NSRC; p++) begin
      bus.src_addr[p*AW +: AW] = AW'(t_src[p]);
      bus.src_used[p] = t_used[p];
    end
    for (int s = 0; s < NSTG; s++) begin
      bus.stg_we[s] = t_we[s];
      bus.stg_rd[s*AW +: AW] = AW'(t_rd[s]);
      bus.stg_rdy[s] = t_rdy[s];
    end
    bus.iss_valid = t_iv;
    bus.iss_we = t_iwe;
    bus.iss_rd = AW'(t_ird);
    bus.iss_lat = LW'(t_ilat);
    bus.flush = t_flush;
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) mcnt[r] = 0;
    msc = 0;
  endtask

  // youngest producer wins; a not-ready youngest match means a hazard
  task automatic model_comb();
    exp_stall = 0;
    for (int p = 0; p < NSRC; p++) begin
      bit nr;
      exp_sel[p] = 0;
      nr = 0;
      if (t_used[p] && t_src[p] != 0) begin
        for (int s = 0; s < NSTG; s++) begin
          if (exp_sel[p] == 0 && t_we[s] && t_rd[s] == t_src[p]) begin
            exp_sel[p] = s + 1;
            nr = !t_rdy[s];
          end
        end
        if (mcnt[t_src[p]] > 0 || nr) exp_stall = 1;
      end
    end
  endtask

  task automatic model_edge();
    if (t_flush) begin
      for (int r = 0; r < 32; r++) mcnt[r] = 0;
    end else begin
      for (int r = 1; r < 32; r++) if (mcnt[r] > 0) mcnt[r] = mcnt[r] - 1;
      if (t_iv && !exp_stall && t_iwe && t_ird != 0) mcnt[t_ird] = t_ilat;
    end
    if (exp_stall && msc < SAT) msc = msc + 1;
  endtask

  // inputs are already pushed (after a negedge); check comb, clock, check count
  task automatic run_cycle();
    #1;
    model_comb();
    for (int p = 0; p < NSRC; p++) chk($sformatf("fwd_sel_p%0d", p), get_sel(p), exp_sel[p]);
    chk("stall", int'(bus.stall), int'(exp_stall));
    @(posedge clk);
    model_edge();
    #1;
    chk("stall_cnt", int'(bus.stall_cnt), msc);
  endtask

  initial begin
    // stage-packed fields below are {s2,s1,s0} / {p2,p1,p0}
    vt[0] = '{src:{5'd0,5'd0,5'd5},  used:3'b001, we:3'b011, rd:{5'd0,5'd5,5'd5},
              rdy:3'b111, esel:{2'd0,2'd0,2'd1}, estall:1'b0};
    vt[1] = '{src:{5'd0,5'd0,5'd5},  used:3'b001, we:3'b110, rd:{5'd5,5'd5,5'd0},
              rdy:3'b111, esel:{2'd0,2'd0,2'd2}, estall:1'b0};
    vt[2] = '{src:{5'd0,5'd7,5'd0},  used:3'b010, we:3'b100, rd:{5'd7,5'd2,5'd3},
              rdy:3'b111, esel:{2'd0,2'd3,2'd0}, estall:1'b0};
    vt[3] = '{src:{5'd0,5'd0,5'd0},  used:3'b111, we:3'b001, rd:{5'd0,5'd0,5'd0},
              rdy:3'b111, esel:{2'd0,2'd0,2'd0}, estall:1'b0};
    vt[4] = '{src:{5'd6,5'd0,5'd0},  used:3'b100, we:3'b011, rd:{5'd0,5'd6,5'd6},
              rdy:3'b110, esel:{2'd1,2'd0,2'd0}, estall:1'b1};
    vt[5] = '{src:{5'd0,5'd0,5'd6},  used:3'b000, we:3'b001, rd:{5'd0,5'd0,5'd6},
              rdy:3'b110, esel:{2'd0,2'd0,2'd0}, estall:1'b0};
    vt[6] = '{src:{5'd0,5'd3,5'd3},  used:3'b011, we:3'b110, rd:{5'd3,5'd3,5'd0},
              rdy:3'b101, esel:{2'd0,2'd2,2'd2}, estall:1'b1};
    vt[7] = '{src:{5'd12,5'd11,5'd10}, used:3'b111, we:3'b111, rd:{5'd10,5'd13,5'd11},
              rdy:3'b111, esel:{2'd0,2'd1,2'd3}, estall:1'b0};

    // reset state
    reset = 1'b0;
    idle(); push(); model_reset();
    #3;
    chk("reset_stall_cnt", int'(bus.stall_cnt), 0);
    chk("reset_stall", int'(bus.stall), 0);
    chk("reset_fwd_sel", int'(bus.fwd_sel), 0);
    @(negedge clk); reset = 1'b1;

    // table vectors against an empty scoreboard
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      idle();
      for (int p = 0; p < NSRC; p++) begin
        t_src[p] = int'(vt[i].src[p]);
        t_used[p] = vt[i].used[p];
      end
      for (int s = 0; s < NSTG; s++) begin
        t_we[s] = vt[i].we[s]; t_rd[s] = int'(vt[i].rd[s]); t_rdy[s] = vt[i].rdy[s];
      end
      push();
      #1;
      for (int p = 0; p < NSRC; p++)
        chk($sformatf("vec%0d_sel_p%0d", i, p), get_sel(p), int'(vt[i].esel[p]));
      chk($sformatf("vec%0d_stall", i), int'(bus.stall), int'(vt[i].estall));
      run_cycle();
    end

    // load rd=9 lat=2, consumer on port 1 right after
    @(negedge clk); idle(); t_iv = 1; t_iwe = 1; t_ird = 9; t_ilat = 2; push(); run_cycle();
    begin
      int base;
      base = msc;
      @(negedge clk); idle(); t_src[1] = 9; t_used[1] = 1; push();
      #1 chk("load_stall_c1", int'(bus.stall), 1);
      run_cycle();
      @(negedge clk); push();
      #1 chk("load_stall_c2", int'(bus.stall), 1);
      run_cycle();
      @(negedge clk); push();
      #1 chk("load_release", int'(bus.stall), 0);
      chk("load_stall_cnt", int'(bus.stall_cnt), base + 2);
      run_cycle();
    end

    // issue then flush
    @(negedge clk); idle(); t_iv = 1; t_iwe = 1; t_ird = 4; t_ilat = 5; push(); run_cycle();
    @(negedge clk); idle(); t_flush = 1; push(); run_cycle();
    @(negedge clk); idle(); t_src[0] = 4; t_used[0] = 1; push();
    #1 chk("flush_clears", int'(bus.stall), 0);
    run_cycle();
    // flush together with issue leaves no entry
    @(negedge clk); idle(); t_flush = 1; t_iv = 1; t_iwe = 1; t_ird = 4; t_ilat = 5; push(); run_cycle();
    @(negedge clk); idle(); t_src[2] = 4; t_used[2] = 1; push();
    #1 chk("flush_beats_issue", int'(bus.stall), 0);
    run_cycle();

    // reset mid-run with an outstanding entry on reg 8
    @(negedge clk); idle(); t_iv = 1; t_iwe = 1; t_ird = 8; t_ilat = 3; push(); run_cycle();
    @(negedge clk); idle(); push();
    #2 reset = 1'b0;
    #1 chk("midrst_stall_cnt", int'(bus.stall_cnt), 0);
    model_reset();
    @(negedge clk); reset = 1'b1; idle(); t_src[0] = 8; t_used[0] = 1; push();
    #1 chk("midrst_stall", int'(bus.stall), 0);
    chk("midrst_fwd_sel", get_sel(0), 0);
    run_cycle();

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      for (int p = 0; p < NSRC; p++) begin
        t_src[p] = int'($urandom_range(0, 7)); t_used[p] = bit'($urandom_range(0, 1));
      end
      for (int s = 0; s < NSTG; s++) begin
        t_we[s] = bit'($urandom_range(0, 1)); t_rd[s] = int'($urandom_range(0, 7));
        t_rdy[s] = ($urandom_range(0, 3) != 0);
      end
      t_iv = bit'($urandom_range(0, 1)); t_iwe = ($urandom_range(0, 3) != 0);
      t_ird = int'($urandom_range(0, 7)); t_ilat = int'($urandom_range(0, 7));
      t_flush = ($urandom_range(0, 15) == 0);
      push();
      run_cycle();
    end

    // hold stall for 2**SW+3 cycles: counter must saturate
    @(negedge clk); idle();
    t_src[0] = 1; t_used[0] = 1; t_we[0] = 1; t_rd[0] = 1; t_rdy[0] = 0; push();
    #1 chk("sat_stall", int'(bus.stall), 1);
    for (int i = 0; i < (2 ** SW) + 3; i++) @(posedge clk);
    #1 chk("sat_hold", int'(bus.stall_cnt), SAT);
    @(posedge clk);
    #1 chk("sat_no_wrap", int'(bus.stall_cnt), SAT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
